// File: rtl/ysyx_23060184_fetch_pc_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_fetch_pc_pkg
// Shared constants, state encoding and helpers for the PC-generation stage.
//   FPC_DATA_WIDTH : PC / address width
//   FPC_RESET_PC   : PC loaded on reset
//   FPC_INST_STEP  : sequential fetch increment (bytes)
//   fpc_state_e    : FSM state encoding (IDLE / ISSUE / WAIT)
// ----------------------------------------------------------------------------
package ysyx_23060184_fetch_pc_pkg;

    localparam int          FPC_DATA_WIDTH = 32;
    localparam logic [31:0] FPC_RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] FPC_INST_STEP  = 32'd4;

    typedef enum logic [1:0] {
        FPC_IDLE  = 2'd0,
        FPC_ISSUE = 2'd1,
        FPC_WAIT  = 2'd2
    } fpc_state_e;

    // Redirect targets are forced to a word boundary.
    function automatic logic [FPC_DATA_WIDTH-1:0] fpc_align(
        input logic [FPC_DATA_WIDTH-1:0] addr
    );
        return {addr[FPC_DATA_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_23060184_fetch_pc_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_fetch_pc_if
// Handshake / redirect bundle between execute, the fetch unit and the
// PC-generation stage.
//   redirect_valid/redirect_pc : control-flow redirect from execute
//   Iready                     : fetch unit can accept an address
//   Ivalid                     : fetch unit holds a completed instruction
//   Eready                     : consumer takes the instruction this cycle
//   Pvalid/pc                  : fetch request offered by the PC stage
//   Fkill                      : completing instruction is wrong-path
// master = PC stage, slave = its environment.
// ----------------------------------------------------------------------------
interface ysyx_23060184_fetch_pc_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  Iready;
    logic                  Ivalid;
    logic                  Eready;
    logic                  Pvalid;
    logic [DATA_WIDTH-1:0] pc;
    logic                  Fkill;

    modport master (
        input  redirect_valid, redirect_pc, Iready, Ivalid, Eready,
        output Pvalid, pc, Fkill
    );

    modport slave (
        output redirect_valid, redirect_pc, Iready, Ivalid, Eready,
        input  Pvalid, pc, Fkill
    );
endinterface

// File: rtl/ysyx_23060184_fetch_pc_redirect_hold.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_fetch_pc_redirect_hold
// Remembers a redirect that arrives while a fetch is already in flight and
// produces the PC to use once that fetch completes.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   accept_i             : current fetch request is accepted this cycle
//   wait_i               : a fetch is outstanding (FSM in WAIT)
//   complete_i           : outstanding fetch completes this cycle
//   redirect_valid_i/_pc_i : redirect from execute
//   pc_i                 : address of the fetch in flight
//   pend_o               : a redirect is pending for the in-flight fetch
//   redirect_tgt_o       : word-aligned redirect target
//   next_pc_o            : PC after completion (redirect > pending > pc+4)
// ----------------------------------------------------------------------------
module ysyx_23060184_fetch_pc_redirect_hold
    import ysyx_23060184_fetch_pc_pkg::*;
#(
    parameter int DATA_WIDTH = FPC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept_i,
    input  logic                  wait_i,
    input  logic                  complete_i,
    input  logic                  redirect_valid_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pend_o,
    output logic [DATA_WIDTH-1:0] redirect_tgt_o,
    output logic [DATA_WIDTH-1:0] next_pc_o
);

    logic                  pend_q,    pend_d;
    logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;

    assign redirect_tgt_o = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

    // A redirect in the accept cycle or during WAIT belongs to the fetch in
    // flight; completion consumes it. A redirect in the completion cycle is
    // not stored because it steers next_pc directly.
    always_comb begin
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (complete_i) begin
            pend_d = 1'b0;
        end else if (redirect_valid_i && (accept_i || wait_i)) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_tgt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        if (redirect_valid_i)
            next_pc_o = redirect_tgt_o;
        else if (pend_q)
            next_pc_o = pend_pc_q;
        else
            next_pc_o = pc_i + DATA_WIDTH'(FPC_INST_STEP);
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/ysyx_23060184_fetch_pc.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_fetch_pc
// PC-generation stage in front of the instruction fetch unit. Offers one
// fetch address at a time (Pvalid/pc, accepted by Iready), waits for the
// fetch to complete (Ivalid && Eready), then steps to pc+4 or to the latest
// redirect. Results of fetches overtaken by a redirect are flagged by Fkill.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   fpc_bus    : ysyx_23060184_fetch_pc_if.master (handshake + redirect)
// Optional (macro YSYX_23060184_FETCH_PERF_EN):
//   perf_fetch_cnt : completions with Fkill=0
//   perf_kill_cnt  : completions with Fkill=1
//   perf_stall_cnt : cycles in ISSUE with Iready=0
// ----------------------------------------------------------------------------
module ysyx_23060184_fetch_pc
    import ysyx_23060184_fetch_pc_pkg::*;
#(
    parameter int                        DATA_WIDTH = FPC_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]     RESET_PC   = FPC_RESET_PC
) (
    input  logic clk,
    input  logic reset,
    ysyx_23060184_fetch_pc_if.master fpc_bus
`ifdef YSYX_23060184_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_kill_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fpc_state_e            state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  pvalid_q;

    logic                  accept;
    logic                  complete;
    logic                  in_wait;
    logic                  pend;
    logic [DATA_WIDTH-1:0] redirect_tgt;
    logic [DATA_WIDTH-1:0] next_pc;

    assign in_wait  = (state_q == FPC_WAIT);
    assign accept   = (state_q == FPC_ISSUE) && pvalid_q && fpc_bus.Iready;
    assign complete = in_wait && fpc_bus.Ivalid && fpc_bus.Eready;

    ysyx_23060184_fetch_pc_redirect_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_redirect_hold (
        .clk              (clk),
        .reset            (reset),
        .accept_i         (accept),
        .wait_i           (in_wait),
        .complete_i       (complete),
        .redirect_valid_i (fpc_bus.redirect_valid),
        .redirect_pc_i    (fpc_bus.redirect_pc),
        .pc_i             (pc_q),
        .pend_o           (pend),
        .redirect_tgt_o   (redirect_tgt),
        .next_pc_o        (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FPC_IDLE;
            pc_q     <= RESET_PC;
            pvalid_q <= 1'b0;
        end else begin
            case (state_q)
                FPC_IDLE: begin
                    state_q  <= FPC_ISSUE;
                    pvalid_q <= 1'b1;
                end
                FPC_ISSUE: begin
                    if (accept) begin
                        // Any redirect in this cycle is captured as pending.
                        pvalid_q <= 1'b0;
                        state_q  <= FPC_WAIT;
                    end else if (fpc_bus.redirect_valid) begin
                        pc_q <= redirect_tgt;
                    end
                end
                FPC_WAIT: begin
                    if (complete) begin
                        pc_q     <= next_pc;
                        pvalid_q <= 1'b1;
                        state_q  <= FPC_ISSUE;
                    end
                end
                default: begin
                    state_q  <= FPC_IDLE;
                    pvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fpc_bus.Pvalid = pvalid_q;
    assign fpc_bus.pc     = pc_q;
    // The in-flight fetch is wrong-path once any redirect has been seen
    // since it was issued, including one arriving with the result itself.
    assign fpc_bus.Fkill  = in_wait && fpc_bus.Ivalid && (pend || fpc_bus.redirect_valid);

`ifdef YSYX_23060184_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] kill_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (complete && !fpc_bus.Fkill)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (complete && fpc_bus.Fkill)
                kill_cnt_q <= kill_cnt_q + 32'd1;
            if ((state_q == FPC_ISSUE) && !fpc_bus.Iready)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_kill_cnt  = kill_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060184_fetch_pc.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060184_fetch_pc
// Random redirects, fetch latencies and consumer back-pressure. A transaction
// model of the fetch stream predicts every issued address and every kill flag
// into queues; a monitor pops and compares whenever the DUT issues a fetch or
// presents a completed instruction.
// ----------------------------------------------------------------------------
module tb_ysyx_23060184_fetch_pc;
    import ysyx_23060184_fetch_pc_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ysyx_23060184_fetch_pc_if #(.DATA_WIDTH(32)) bus ();

`ifdef YSYX_23060184_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_kill_cnt, perf_stall_cnt;
`endif

    ysyx_23060184_fetch_pc dut (
        .clk     (clk),
        .reset   (reset),
        .fpc_bus (bus)
`ifdef YSYX_23060184_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_kill_cnt  (perf_kill_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_pc_q[$];
    logic        exp_kill_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Transaction-level model of the fetch stream.
    bit          m_idle, m_offer, m_out, m_redir;
    logic [31:0] m_addr, m_tgt;
    logic [31:0] m_fetch, m_kill, m_stall;
    int          lat;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a - (a % 4);
    endfunction

    task automatic model_reset();
        m_idle = 1; m_offer = 0; m_out = 0; m_redir = 0;
        m_addr = RST_PC; m_tgt = 0; lat = 0;
        m_fetch = 0; m_kill = 0; m_stall = 0;
    endtask

    // Monitor: compare against the scoreboard whenever the DUT shows output.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.Pvalid && bus.Iready) begin
                    if (exp_pc_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL issue_unexpected: got pc %h expected no fetch at %0t", bus.pc, $time);
                    end else begin
                        check("issue_pc", bus.pc, exp_pc_q.pop_front());
                    end
                end
                if (bus.Ivalid) begin
                    if (exp_kill_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL kill_unexpected: got Fkill %b expected no result at %0t", bus.Fkill, $time);
                    end else begin
                        check("fkill", 32'(bus.Fkill), 32'(exp_kill_q.pop_front()));
                    end
                end
            end
        end
    end

    // Driver + model.
    initial begin
        bit          prev_reset, prev_idle, want_reset, rv, iv, er, ir;
        logic [31:0] rpc;
        int          rst_left;

        bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.Iready = 0; bus.Ivalid = 0; bus.Eready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        prev_reset = 1; prev_idle = 0; want_reset = 0; rst_left = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            if (prev_reset) begin
                check("reset_pc", bus.pc, RST_PC);
                check("reset_pvalid", 32'(bus.Pvalid), 32'd0);
                check("reset_fkill", 32'(bus.Fkill), 32'd0);
            end
            if (prev_idle)
                check("first_pvalid", 32'(bus.Pvalid), 32'd1);
            prev_idle = 0;

            if (cyc % 600 == 599) want_reset = 1;
            // Prefer aborting a fetch in flight.
            if (want_reset && m_out) begin
                want_reset = 0;
                rst_left = 2;
            end
            if (rst_left > 0) begin
                reset = 1;
                bus.redirect_valid = 0; bus.Iready = 0; bus.Ivalid = 0; bus.Eready = 0;
                model_reset();
                rst_left--;
                prev_reset = 1;
                continue;
            end
            prev_reset = 0;
            reset = 0;

            rv  = ($urandom_range(0, 5) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            ir  = $urandom_range(0, 1);
            if (m_out) begin
                if (lat > 0) begin lat--; iv = 0; end
                else iv = 1;
                er = iv ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            end else begin
                // Stray results outside a fetch, always one in the idle cycle.
                iv = m_idle ? 1'b1 : ($urandom_range(0, 19) == 0);
                er = $urandom_range(0, 1);
            end
            bus.redirect_valid = rv; bus.redirect_pc = rpc;
            bus.Iready = ir; bus.Ivalid = iv; bus.Eready = er;

            if (m_idle) begin
                if (iv) exp_kill_q.push_back(1'b0);
                m_idle = 0; m_offer = 1; prev_idle = 1;
            end else if (m_offer) begin
                if (iv) exp_kill_q.push_back(1'b0);
                if (ir) begin
                    exp_pc_q.push_back(m_addr);
                    m_offer = 0; m_out = 1;
                    m_redir = rv;
                    if (rv) m_tgt = word_of(rpc);
                    lat = $urandom_range(0, 3);
                end else begin
                    m_stall++;
                    if (rv) m_addr = word_of(rpc);
                end
            end else if (m_out) begin
                if (rv) begin m_redir = 1; m_tgt = word_of(rpc); end
                if (iv) exp_kill_q.push_back(m_redir);
                if (iv && er) begin
                    if (m_redir) m_kill++; else m_fetch++;
                    m_addr  = m_redir ? m_tgt : m_addr + 4;
                    m_redir = 0; m_out = 0; m_offer = 1;
                end
            end
        end

        @(posedge clk); #1;
`ifdef YSYX_23060184_FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        check("perf_kill_cnt",  perf_kill_cnt,  m_kill);
        check("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
        bus.redirect_valid = 0; bus.Iready = 0; bus.Ivalid = 0; bus.Eready = 0;
        @(posedge clk); #1;
        check("issue_queue_drained", exp_pc_q.size(), 32'd0);
        check("kill_queue_drained", exp_kill_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060184_fetch_pc.md
Name: ysyx_23060184_fetch_pc

Overview:
- PC-generation stage directly upstream of the instruction-memory fetch unit.
- Holds the architectural fetch PC and offers it with a valid/ready handshake (Pvalid/Iready).
- Keeps exactly one fetch outstanding and advances on fetch completion.
- Takes control-flow redirects from execute and marks wrong-path fetch results for discard.

Parameters:
- DATA_WIDTH, 32, PC/address width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  redirect request from execute (branch/jump/trap), one-cycle pulse.
- redirect_pc  in  DATA_WIDTH  redirect target.
- Iready  in  1  fetch unit idle and able to accept an address.
- Ivalid  in  1  fetch unit holds a completed instruction.
- Eready  in  1  downstream consumer accepts the instruction this cycle.
- Pvalid  out  1  pc is valid and requests a fetch.
- pc  out  DATA_WIDTH  fetch address presented to the fetch unit.
- Fkill  out  1  the instruction now completing (Ivalid) is wrong-path and must be dropped.

Behaviour:
- Reset values: pc=RESET_PC, Pvalid=0, Fkill=0, state=IDLE, pend=0, pend_pc=0.
- One fetch is outstanding at a time; Pvalid and pc are registered.
- State IDLE: entered on reset; lasts one cycle after reset deasserts. Next state ISSUE with Pvalid<=1.
- State ISSUE: Pvalid=1, pc stable.
  - Pvalid&&Iready (accept): Pvalid<=0, go to WAIT.
  - redirect_valid without accept: pc<=redirect_pc; stay in ISSUE with Pvalid=1.
  - redirect_valid in the accept cycle: the old pc has already been issued. Go to WAIT with pend<=1 and pend_pc<=redirect_pc.
- State WAIT: Pvalid=0.
  - redirect_valid: pend<=1, pend_pc<=redirect_pc. The latest redirect overwrites an earlier pending one.
  - Completion is Ivalid&&Eready:
    - pc<=pend ? pend_pc : pc+4.
    - pend<=0, Pvalid<=1, go to ISSUE.
  - Redirect coinciding with completion: the redirect wins. pc<=redirect_pc, and Fkill=1 that cycle.
- Fkill is combinational: state==WAIT && Ivalid && (pend || redirect_valid).
- Fkill is only meaningful while Ivalid=1; the consumer drops that instruction.
- Arithmetic: pc+4 wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 0).
- Redirect targets force bits [1:0] to zero.
- A reset mid-fetch aborts all state in the same edge. A later Ivalid from the fetch unit is ignored: state is not WAIT, so Fkill=0 and there is no effect.
- Ivalid seen outside WAIT is ignored.

Optional Feature:
- Macro YSYX_23060184_FETCH_PERF_EN adds three outputs, all reset to 0 and wrapping at 2^32:
  - perf_fetch_cnt (32b): counts completions with Fkill=0.
  - perf_kill_cnt (32b): counts completions with Fkill=1.
  - perf_stall_cnt (32b): counts cycles spent in ISSUE with Iready=0.
- Without the macro: the outputs and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - DATA_WIDTH.
  - RESET_PC.
  - State encodings FPC_IDLE=2'd0, FPC_ISSUE=2'd1, FPC_WAIT=2'd2.
  - INST_STEP=4.
- Natural sub-module: ysyx_23060184_redirect_hold. Owns the pend/pend_pc register pair and the next-pc mux (pend ? pend_pc : pc+4, with redirect override).
- The top level holds the FSM and the outputs.

Test Plan:
- Reset sequence → after reset deasserts: pc=32'h8000_0000, Pvalid=0 for 1 cycle, then Pvalid=1.
- Sequential fetch with Iready=1, then Ivalid&&Eready 3 cycles later → pc steps 8000_0000, 8000_0004, 8000_0008; Fkill=0 throughout.
- Redirect in ISSUE to 32'h8000_0103 while Iready=0 → pc=8000_0100 next cycle, Pvalid stays 1, no extra fetch issued.
- Redirect in WAIT to 8000_0200, completion two cycles later → Fkill=1 in the completion cycle; next pc=8000_0200.
- Redirect in the same cycle as completion (target 8000_0300) → Fkill=1, next pc=8000_0300.
- Two redirects in WAIT (8000_0400 then 8000_0500) → next pc=8000_0500.
- Wrap case: pc=32'hFFFF_FFFC completes → pc=0.
- Reset asserted in WAIT, then Ivalid pulses → Fkill=0, pc=RESET_PC.
- With PERF_EN: 3 good and 1 killed fetch → fetch_cnt=3, kill_cnt=1.
